// File: rtl/la_dinvpipe_pkg.sv
// Shared definitions for la_dinvpipe: reset data value and odd-parity helper.
// Used by the top and the stage sub-module.
package la_dinvpipe_pkg;

   // One bit of the data reset value; replicate to any width.
   localparam logic RST_BIT   = 1'b0;

   // Widest vector the parity helper accepts (zero extension keeps XOR intact).
   localparam int   PAR_MAX_W = 1025;

   // Returns 1 when the vector holds an odd number of ones.
   function automatic logic par_odd(input logic [PAR_MAX_W-1:0] v);
      return ^v;
   endfunction

endpackage

// File: rtl/la_dinvpipe_stage.sv
// One elastic pipeline register: valid bit plus payload, loaded on enable,
// asynchronously cleared by nreset.
module la_dinvpipe_stage
   import la_dinvpipe_pkg::*;
#(
   parameter int DW   = 8,
   parameter     PROP = "DEFAULT"
)(
   input  logic          clk,
   input  logic          nreset,
   input  logic          load,
   input  logic          d_valid,
   input  logic [DW-1:0] d,
   output logic          q_valid,
   output logic [DW-1:0] q
);

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         q_valid <= 1'b0;
         q       <= {DW{RST_BIT}};
      end else if (load) begin
         q_valid <= d_valid;
         q       <= d;
      end
   end

endmodule

// File: rtl/la_dinvpipe.sv
// Elastic valid/ready retiming pipeline taking an inverted-polarity bus and
// delivering it in true polarity; registered in_ready via a one-word skid buffer.
// Optional parity path enabled by defining LA_DINVPIPE_PARITY_EN.
module la_dinvpipe
   import la_dinvpipe_pkg::*;
#(
   parameter int DW    = 8,
   parameter int DEPTH = 2,
   parameter     PROP  = "DEFAULT"
)(
   input  logic          clk,
   input  logic          nreset,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_dn,
`ifdef LA_DINVPIPE_PARITY_EN
   input  logic          in_pn,
   output logic          out_perr,
`endif
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_d
);

`ifdef LA_DINVPIPE_PARITY_EN
   localparam int PW = 1;
`else
   localparam int PW = 0;
`endif
   localparam int SW = DW + PW;

   logic [SW-1:0]    entry_raw;
   logic [DEPTH-1:0] sv;
   logic [DEPTH-1:0] ld;
   logic [SW-1:0]    sq [DEPTH];

   logic             skid_full;
   logic             skid_full_nxt;
   logic [SW-1:0]    skid_d;
   logic             xfer;
   logic             to_skid;
   logic             s0_valid;
   logic [SW-1:0]    s0_d;

`ifdef LA_DINVPIPE_PARITY_EN
   assign entry_raw = {in_dn, in_pn};
`else
   assign entry_raw = in_dn;
`endif

   // Load enables ripple back from the output: a stage loads when empty or draining.
   always_comb begin
      ld            = '0;
      ld[DEPTH-1]   = ~sv[DEPTH-1] | out_ready;
      for (int i = DEPTH-2; i >= 0; i--) begin
         ld[i] = ~sv[i] | ld[i+1];
      end
   end

   assign xfer          = in_valid & in_ready;
   assign to_skid       = xfer & ~ld[0];
   assign s0_valid      = skid_full | xfer;
   assign s0_d          = skid_full ? skid_d : ~entry_raw;
   assign skid_full_nxt = skid_full ? ~ld[0] : to_skid;

   // Skid stores the already-inverted word; in_ready mirrors the next skid state.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         skid_full <= 1'b0;
         in_ready  <= 1'b0;
         skid_d    <= {SW{RST_BIT}};
      end else begin
         skid_full <= skid_full_nxt;
         in_ready  <= ~skid_full_nxt;
         if (to_skid) begin
            skid_d <= ~entry_raw;
         end
      end
   end

   for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      logic          dv;
      logic [SW-1:0] dd;

      if (i == 0) begin : g_head
         assign dv = s0_valid;
         assign dd = s0_d;
      end else begin : g_body
         assign dv = sv[i-1];
         assign dd = sq[i-1];
      end

      la_dinvpipe_stage #(
         .DW   (SW),
         .PROP (PROP)
      ) u_stage (
         .clk     (clk),
         .nreset  (nreset),
         .load    (ld[i]),
         .d_valid (dv),
         .d       (dd),
         .q_valid (sv[i]),
         .q       (sq[i])
      );
   end

   assign out_valid = sv[DEPTH-1];
   assign out_d     = sq[DEPTH-1][SW-1:PW];

`ifdef LA_DINVPIPE_PARITY_EN
   assign out_perr  = out_valid & ~par_odd(PAR_MAX_W'(sq[DEPTH-1]));
`endif

endmodule

// File: doc/la_dinvpipe.md
Name: la_dinvpipe

Overview:
Elastic valid/ready retiming pipeline that accepts a bus carried in inverted polarity and delivers it in true polarity. It is the receive-side counterpart of inverting-output flop storage: a single inversion is applied at capture (stage0 <= ~in_dn). It is used wherever qn-style registered buses cross a long route and need retiming plus backpressure. Input ready is registered through a skid buffer, so there is no combinational ready path from output to input.

Parameters:
DW, 8, data width in bits (>=1)
DEPTH, 2, number of pipeline register stages (>=1)
PROP, "DEFAULT", implementation property string, passed through to sub-modules

Ports:
clk  input  1  clock, all logic on posedge
nreset  input  1  asynchronous active-low reset
in_valid  input  1  upstream data valid
in_ready  output  1  registered; upstream may transfer when in_valid & in_ready
in_dn  input  DW  input data, inverted polarity
out_valid  output  1  output data valid
out_ready  input  1  downstream accepts when out_valid & out_ready
out_d  output  DW  output data, true polarity (= ~in_dn as accepted)

Behaviour:
- Reset is asynchronous, active-low, using the single clock clk and reset nreset. While nreset=0:
  - all stage valid bits = 0 and skid_full = 0
  - out_valid = 0, in_ready = 0
  - all data registers = 0, so out_d = 0
- First cycle after release: in_ready = 1.
- Inversion: exactly once, at entry to stage 0. Stages 1..DEPTH-1 and the skid copy bits unmodified. Skid stores the already-inverted value.
- Stage advance:
  - stage i loads from stage i-1 (or from the entry point for i=0) when stage i is empty or is draining that cycle.
  - drain of the last stage = out_valid & out_ready. Ready between stages is combinational.
  - out_valid = valid of stage DEPTH-1; out_d = its data.
- Latency: with no stalls, a word accepted at edge N appears with out_valid=1 after edge N+DEPTH-1 (DEPTH register stages). Throughput is 1 word/cycle.
- Skid buffer:
  - if a transfer occurs while stage 0 cannot load, the word goes to skid, skid_full=1, and in_ready=0 from the next cycle.
  - entry-point priority: skid before the new input.
  - when stage 0 loads from skid, skid_full=0 and in_ready=1 the next cycle.
  - in_ready = ~skid_full (registered); upstream never sees a combinational path from out_ready.
- Boundaries:
  - full pipeline + out_ready=0: nothing moves and out_d is held stable.
  - full pipeline + simultaneous accept and drain: every stage shifts; no bubble, no loss.
  - in_valid=0: bubbles propagate and are never presented as valid.
  - out_valid, once asserted, holds with stable out_d until accepted.
  - reset mid-transfer: all in-flight words are discarded; no partial word is emitted after release.

Optional Feature:
Macro LA_DINVPIPE_PARITY_EN.
- Defined:
  - adds input in_pn (1 bit, inverted odd parity of in_dn) and output out_perr (1 bit).
  - parity travels with the data (inverted at stage 0, like data).
  - out_perr = out_valid & (^{out_d, parity} == 0), i.e. odd parity violated.
  - out_perr resets to 0 and is combinational from the last stage.
- Undefined: no parity ports, no parity storage; behaviour otherwise identical.

Decomposition:
- Shared stdlib package: the reset data constant (all zeros, width-generic) and the parity function (odd parity over a vector). No typedefs needed beyond these.
- One natural sub-module: la_dinvpipe_stage.
  - one valid+data register with load enable and async reset.
  - instantiated DEPTH times via generate.
  - skid and inversion logic stay in the top.

Test Plan:
- Reset with nreset=0 mid-stream -> out_valid=0, out_d=8'h00, in_ready=0 asynchronously; in_ready=1 on the first edge after release.
- Stream in_dn=8'hFE,8'hFD,8'hFB with out_ready=1, DEPTH=2 -> out_d=8'h01,8'h02,8'h04 on consecutive cycles, first valid 2 edges after first accept.
- Fill with out_ready=0 -> exactly DEPTH+1=3 words accepted, then in_ready=0; out_d is held constant for 10 stall cycles; release out_ready -> the 3 words are delivered in order, no duplicates.
- Random out_ready (50%) and random in_valid, 1000 words -> output sequence equals bitwise-inverted input sequence; no loss, no reorder.
- Simultaneous accept+drain on a full pipe for 20 cycles -> 20 words out, occupancy constant, in_ready stays at its prior value.
- With LA_DINVPIPE_PARITY_EN: send in_dn=8'hFE with correct in_pn, then with flipped in_pn -> out_perr=0, then 1, only while out_valid=1.
